// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the comma-aligned serial link.
// Holds the byte width, the default COMMA byte and the link state encoding.
package serial_link_pkg;

  localparam int BYTE_W = 8;
  localparam int BIT_CNT_W = $clog2(BYTE_W);
  localparam int SYNC_CNT_W = 4;

  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } link_state_e;

endpackage

// File: rtl/serial_tx_hold_reg.sv
// One-deep valid/ready holding register between the byte producer and the
// serializer; READY is high exactly when the slot is empty.
module serial_tx_hold_reg
  import serial_link_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              drain_i,
  output logic [BYTE_W-1:0] data_o,
  output logic              valid_o
);

  logic              hold_valid_q;
  logic [BYTE_W-1:0] hold_q;
  logic              accept;

  assign accept = valid_i && !hold_valid_q;

  // NOTE: sequential state is written with <= only, so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_valid_q <= 1'b0;
    end else if (drain_i) begin
      hold_valid_q <= 1'b0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
    end
  end

  // NOTE: the payload is never reset; hold_valid_q alone qualifies it.
  always_ff @(posedge CLK) begin
    if (accept) begin
      hold_q <= data_i;
    end
  end

  assign ready_o = ~hold_valid_q;
  assign data_o  = hold_q;
  assign valid_o = hold_valid_q;

endmodule

// File: rtl/parallel_serial_tx.sv
// Byte-to-bit serializer: COMMA burst after reset, then user bytes MSB-first
// with COMMA idle fill. Define PARALLEL_SERIAL_TX_RESYNC_EN to add the RESYNC input.
module parallel_serial_tx
  import serial_link_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int                SYNC_COUNT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [BYTE_W-1:0] DATA_IN,
  input  logic              VALID_IN,
`ifdef PARALLEL_SERIAL_TX_RESYNC_EN
  input  logic              RESYNC,
`endif
  output logic              READY_OUT,
  output logic              DATA_OUT,
  output logic              TX_DATA_ACTIVE,
  output logic              SYNC_DONE
);

  localparam logic [SYNC_CNT_W-1:0] LAST_SYNC = SYNC_CNT_W'(SYNC_COUNT - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BYTE_W - 1);

  link_state_e          state_q;
  logic [BYTE_W-1:0]    shreg_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [SYNC_CNT_W-1:0] sync_cnt_q;
  logic                 cur_is_data_q;

  logic [BYTE_W-1:0]    hold_data;
  logic                 hold_valid;
  logic                 hold_ready;

  logic                 boundary;
  logic                 burst_end;
  logic                 resync_now;
  logic                 drain_d;
  logic [BYTE_W-1:0]    next_byte_d;

  serial_tx_hold_reg u_hold (
    .CLK     (CLK),
    .RESET   (RESET),
    .data_i  (DATA_IN),
    .valid_i (VALID_IN),
    .ready_o (hold_ready),
    .drain_i (drain_d),
    .data_o  (hold_data),
    .valid_o (hold_valid)
  );

`ifdef PARALLEL_SERIAL_TX_RESYNC_EN
  logic resync_pend_q;

  // A pulse on a boundary cycle is kept pending and acts at the following boundary.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      resync_pend_q <= 1'b0;
    end else if (RESYNC) begin
      resync_pend_q <= 1'b1;
    end else if (boundary) begin
      resync_pend_q <= 1'b0;
    end
  end

  assign resync_now = resync_pend_q;
`else
  assign resync_now = 1'b0;
`endif

  assign boundary  = (bit_cnt_q == LAST_BIT);
  // The boundary closing the burst already takes user data, so exactly SYNC_COUNT commas go out.
  assign burst_end = (state_q == SYNC) && (sync_cnt_q == LAST_SYNC);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    drain_d     = 1'b0;
    next_byte_d = COMMA;
    if (boundary && !resync_now && hold_valid && ((state_q == RUN) || burst_end)) begin
      drain_d     = 1'b1;
      next_byte_d = hold_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= SYNC;
      shreg_q       <= COMMA;
      bit_cnt_q     <= '0;
      sync_cnt_q    <= '0;
      cur_is_data_q <= 1'b0;
    end else if (boundary) begin
      shreg_q       <= next_byte_d;
      bit_cnt_q     <= '0;
      cur_is_data_q <= drain_d;
      if (resync_now) begin
        state_q    <= SYNC;
        sync_cnt_q <= '0;
      end else if (state_q == SYNC) begin
        sync_cnt_q <= sync_cnt_q + 1'b1;
        if (burst_end) begin
          state_q <= RUN;
        end
      end
    end else begin
      shreg_q   <= {shreg_q[BYTE_W-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign DATA_OUT       = shreg_q[BYTE_W-1];
  assign READY_OUT      = hold_ready;
  assign TX_DATA_ACTIVE = cur_is_data_q;
  assign SYNC_DONE      = (state_q == RUN);

endmodule

// File: tb/tb_parallel_serial_tx.sv
// Bench for parallel_serial_tx: byte-level line model checked every cycle,
// plus directed scenarios with literal bit patterns.
module tb_parallel_serial_tx;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         SYNC_COUNT = 4;

  logic       CLK      = 1'b0;
  logic       RESET    = 1'b1;
  logic [7:0] DATA_IN  = 8'h00;
  logic       VALID_IN = 1'b0;
  logic       READY_OUT;
  logic       DATA_OUT;
  logic       TX_DATA_ACTIVE;
  logic       SYNC_DONE;
`ifdef PARALLEL_SERIAL_TX_RESYNC_EN
  logic       RESYNC = 1'b0;
`endif

  always #5 CLK = ~CLK;

  parallel_serial_tx #(
    .COMMA      (COMMA),
    .SYNC_COUNT (SYNC_COUNT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .DATA_IN        (DATA_IN),
    .VALID_IN       (VALID_IN),
`ifdef PARALLEL_SERIAL_TX_RESYNC_EN
    .RESYNC         (RESYNC),
`endif
    .READY_OUT      (READY_OUT),
    .DATA_OUT       (DATA_OUT),
    .TX_DATA_ACTIVE (TX_DATA_ACTIVE),
    .SYNC_DONE      (SYNC_DONE)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Line model: byte slots of 8 cycles counted from reset release; the first
  // SYNC_COUNT slots are COMMA, later slots carry the held byte if one was
  // held before the slot started, else COMMA.
  bit         m_live = 1'b0;
  int         m_n;
  logic [7:0] m_cur;
  bit         m_data;
  bit         m_hv;
  logic [7:0] m_hold;
  bit         m_acc;

  always @(posedge CLK) begin
    if (RESET) begin
      m_live = 1'b1;
      m_n    = 0;
      m_cur  = COMMA;
      m_data = 1'b0;
      m_hv   = 1'b0;
    end else if (m_live) begin
      m_acc = VALID_IN && !m_hv;
      if (m_n % 8 == 7) begin
        if ((m_n / 8 + 1) >= SYNC_COUNT && m_hv) begin
          m_cur  = m_hold;
          m_data = 1'b1;
          m_hv   = 1'b0;
        end else begin
          m_cur  = COMMA;
          m_data = 1'b0;
        end
      end
      if (m_acc) begin
        m_hold = DATA_IN;
        m_hv   = 1'b1;
      end
      m_n++;
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      check("line_bit",  DATA_OUT,       m_cur[3'(7 - m_n % 8)]);
      check("ready",     READY_OUT,      !m_hv);
      check("tx_active", TX_DATA_ACTIVE, m_data);
      check("sync_done", SYNC_DONE,      (m_n / 8) >= SYNC_COUNT);
    end
  end

  // Reassemble user bytes and TX_DATA_ACTIVE run lengths from the line.
  logic [7:0] mon_acc;
  int         mon_bits = 0;
  int         run_len  = 0;
  logic [7:0] got_bytes[$];
  int         runs[$];

  always @(negedge CLK) begin
    if (m_live) begin
      if (TX_DATA_ACTIVE === 1'b1) begin
        run_len++;
        mon_acc = {mon_acc[6:0], DATA_OUT};
        mon_bits++;
        if (mon_bits == 8) begin
          got_bytes.push_back(mon_acc);
          mon_bits = 0;
        end
      end else begin
        if (run_len > 0) runs.push_back(run_len);
        run_len  = 0;
        mon_bits = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int guard = 0;
    while ((m_n % 8) != p && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) check("wait_phase_timeout", m_n % 8, p);
  endtask

  task automatic offer(input logic [7:0] b);
    logic acc = 1'b0;
    DATA_IN  = b;
    VALID_IN = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge CLK);
      acc = READY_OUT;
      step();
    end
    VALID_IN = 1'b0;
    if (!acc) check("offer_timeout", acc, 1'b1);
  endtask

  task automatic capture(input int k, output logic [63:0] d, output logic [63:0] t,
                         output logic [63:0] r, output logic [63:0] s);
    d = '0; t = '0; r = '0; s = '0;
    for (int i = 0; i < k; i++) begin
      @(negedge CLK);
      d = {d[62:0], DATA_OUT};
      t = {t[62:0], TX_DATA_ACTIVE};
      r = {r[62:0], READY_OUT};
      s = {s[62:0], SYNC_DONE};
    end
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1'b1;
    repeat (cycles) step();
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [63:0] d, t, r, s;
  logic [7:0]  exp_bytes[6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h3C, 8'h5A};
  int          exp_runs[5]  = '{8, 24, 8, 5, 8};

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge CLK);
    check("rst_data_out",  DATA_OUT,       1'b1);
    check("rst_ready",     READY_OUT,      1'b1);
    check("rst_tx_active", TX_DATA_ACTIVE, 1'b0);
    check("rst_sync_done", SYNC_DONE,      1'b0);
    step();
    RESET = 1'b0;

    // Four-comma burst, SYNC_DONE rises at cycle 32
    capture(32, d, t, r, s);
    check("burst_bits",      d[31:0], 32'hBCBC_BCBC);
    check("burst_tx_active", t[31:0], 32'h0);
    check("burst_sync_done", s[31:0], 32'h0);
    @(negedge CLK);
    check("c32_sync_done", SYNC_DONE,      1'b1);
    check("c32_data_out",  DATA_OUT,       1'b1);
    check("c32_tx_active", TX_DATA_ACTIVE, 1'b0);
    step();

    // A5 accepted mid-byte
    wait_phase(3);
    DATA_IN  = 8'hA5;
    VALID_IN = 1'b1;
    step();
    VALID_IN = 1'b0;
    capture(12, d, t, r, s);
    check("a5_bits",      d[11:0], 12'hCA5);
    check("a5_tx_active", t[11:0], 12'h0FF);
    check("a5_ready",     r[11:0], 12'h0FF);
    step();

    // Back-to-back bytes
    offer(8'h01);
    offer(8'h02);
    offer(8'h03);
    repeat (40) step();

    // Accept on the last-bit cycle
    wait_phase(7);
    DATA_IN  = 8'h3C;
    VALID_IN = 1'b1;
    step();
    VALID_IN = 1'b0;
    capture(16, d, t, r, s);
    check("3c_bits",      d[15:0], 16'hBC3C);
    check("3c_tx_active", t[15:0], 16'h00FF);
    step();

    // Reset mid-byte with a byte held
    wait_phase(2);
    DATA_IN  = 8'h77;
    VALID_IN = 1'b1;
    step();
    VALID_IN = 1'b0;
    wait_phase(1);
    DATA_IN  = 8'h88;
    VALID_IN = 1'b1;
    step();
    VALID_IN = 1'b0;
    wait_phase(4);
    do_reset(2);
    capture(40, d, t, r, s);
    check("rst2_bits",      d[39:0], 40'hBC_BCBC_BCBC);
    check("rst2_tx_active", t[39:0], 40'h0);
    check("rst2_ready",     r[39:0], 40'hFF_FFFF_FFFF);
    check("rst2_sync_done", s[39:0], 40'hFF);

    // Byte offered during SYNC
    do_reset(2);
    repeat (3) step();
    DATA_IN  = 8'h5A;
    VALID_IN = 1'b1;
    step();
    VALID_IN = 1'b0;
    capture(36, d, t, r, s);
    check("5a_bits",      d[35:0], 36'hC_BCBC_BC5A);
    check("5a_ready",     r[35:0], 36'h0_0000_00FF);
    check("5a_tx_active", t[35:0], 36'h0_0000_00FF);
    repeat (10) step();

    // Everything that went out as user data
    check("byte_count", got_bytes.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_bytes.size()) check($sformatf("byte_%0d", i), got_bytes[i], exp_bytes[i]);
    end
    check("run_count", runs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < runs.size()) check($sformatf("run_%0d", i), runs[i], exp_runs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
